// File: rtl/ifmap_repack_fifo.sv
// ifmap_repack_fifo: repacks fixed-width DRAM ifmap words into per-row output
// chunks of up to LANES elements. Each row starts at lane 0; the final chunk of
// a row is zero-padded and marked through a contiguous lane mask.
module ifmap_repack_fifo #(
  parameter int IN_W   = 64,
  parameter int ELEM_W = 8,
  parameter int LANES  = 8,
  parameter int BUF_W  = 256,
  parameter int LEN_W  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         start,
  input  logic [LEN_W-1:0]             row_len,
  input  logic [LEN_W-1:0]             rows_per_frame,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [IN_W-1:0]              in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*ELEM_W-1:0]      out_data,
  output logic [LANES-1:0]             out_keep,
  output logic [LEN_W-1:0]             out_addr,
  output logic                         out_row_last,
  output logic                         out_frame_end,
  output logic                         busy,
  output logic [$clog2(BUF_W+1)-1:0]   level
);

  localparam int OUT_W = LANES * ELEM_W;
  localparam int LVL_W = $clog2(BUF_W + 1);
  localparam logic [LEN_W-1:0] LANES_LEN = LEN_W'(LANES);
  localparam logic [LVL_W-1:0] PUSH_MAX  = LVL_W'(BUF_W - IN_W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Packed element buffer: element 0 of the stream always sits at bit 0.
  // Bits at or above r_level are kept at zero so a new word can be OR-ed in.
  logic [BUF_W-1:0]  r_buf;
  logic [LVL_W-1:0]  r_level;

  // Frame configuration captured at start (zero already mapped to one).
  logic [LEN_W-1:0]  r_row_len;
  logic [LEN_W-1:0]  r_rows;

  // Position within the frame.
  logic [LEN_W-1:0]  r_row_rem;    // elements still to emit in the current row
  logic [LEN_W-1:0]  r_chunk_idx;  // index of the next chunk within the row
  logic [LEN_W-1:0]  r_row_idx;    // index of the current row within the frame

  // Output register.
  logic              r_out_valid;
  logic [OUT_W-1:0]  r_out_data;
  logic [LANES-1:0]  r_out_keep;
  logic [LEN_W-1:0]  r_out_addr;
  logic              r_out_row_last;
  logic              r_out_frame_end;

  logic [LEN_W-1:0]  w_take_len;
  logic [LVL_W-1:0]  w_take_bits;
  logic              w_row_last;
  logic              w_frame_end;
  logic              w_pop;
  logic              w_in_ready;
  logic              w_push;
  logic [BUF_W-1:0]  w_buf_sh;
  logic [LVL_W-1:0]  w_level_sh;
  logic [BUF_W-1:0]  w_buf_next;
  logic [LVL_W-1:0]  w_level_next;
  logic [LANES-1:0]  w_keep;
  logic [OUT_W-1:0]  w_chunk;

  // Chunk size: the rest of the row, capped at the lane count.
  assign w_take_len  = (r_row_rem < LANES_LEN) ? r_row_rem : LANES_LEN;
  assign w_take_bits = LVL_W'(w_take_len) * LVL_W'(ELEM_W);
  assign w_row_last  = (r_row_rem <= LANES_LEN);
  assign w_frame_end = w_row_last && (r_row_idx == (r_rows - LEN_W'(1)));

  // Pop needs a free output slot and the whole chunk already buffered.
  assign w_pop = (r_state == S_RUN) && (!r_out_valid || out_ready) &&
                 (r_level >= w_take_bits);

  // Push acceptance depends on the registered level only, so there is no
  // combinational path from out_ready to in_ready.
  assign w_in_ready = (r_state == S_RUN) && (r_level <= PUSH_MAX);
  assign w_push     = in_valid && w_in_ready;

  // Shift out the popped chunk first, then append the new word at the
  // post-shift level, so a same-cycle push and pop neither lose nor repeat bits.
  assign w_buf_sh     = w_pop ? (r_buf >> w_take_bits) : r_buf;
  assign w_level_sh   = w_pop ? (r_level - w_take_bits) : r_level;
  assign w_buf_next   = w_push ? (w_buf_sh | ({{(BUF_W-IN_W){1'b0}}, in_data} << w_level_sh))
                               : w_buf_sh;
  assign w_level_next = w_level_sh + (w_push ? LVL_W'(IN_W) : LVL_W'(0));

  // Lane mask and zero-padded chunk data taken from the bottom of the buffer.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_keep[gi] = (LEN_W'(gi) < w_take_len);
      assign w_chunk[gi*ELEM_W +: ELEM_W] = w_keep[gi] ? r_buf[gi*ELEM_W +: ELEM_W]
                                                         : {ELEM_W{1'b0}};
    end
  endgenerate

  // State register; clear forces IDLE ahead of any transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else if (clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: start opens a frame, the final pop drains, handoff idles.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_state_next = S_RUN;
      S_RUN:   if (w_pop && w_frame_end) w_state_next = S_DRAIN;
      S_DRAIN: if (r_out_valid && out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Buffer, frame counters and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf           <= '0;
      r_level         <= '0;
      r_row_len       <= '0;
      r_rows          <= '0;
      r_row_rem       <= '0;
      r_chunk_idx     <= '0;
      r_row_idx       <= '0;
      r_out_valid     <= 1'b0;
      r_out_data      <= '0;
      r_out_keep      <= '0;
      r_out_addr      <= '0;
      r_out_row_last  <= 1'b0;
      r_out_frame_end <= 1'b0;
    end else if (clear) begin
      r_buf           <= '0;
      r_level         <= '0;
      r_row_len       <= '0;
      r_rows          <= '0;
      r_row_rem       <= '0;
      r_chunk_idx     <= '0;
      r_row_idx       <= '0;
      r_out_valid     <= 1'b0;
      r_out_data      <= '0;
      r_out_keep      <= '0;
      r_out_addr      <= '0;
      r_out_row_last  <= 1'b0;
      r_out_frame_end <= 1'b0;
    end else begin
      r_buf   <= w_buf_next;
      r_level <= w_level_next;

      if (r_state == S_IDLE && start) begin
        r_row_len   <= (row_len == '0) ? LEN_W'(1) : row_len;
        r_rows      <= (rows_per_frame == '0) ? LEN_W'(1) : rows_per_frame;
        r_row_rem   <= (row_len == '0) ? LEN_W'(1) : row_len;
        r_chunk_idx <= '0;
        r_row_idx   <= '0;
      end

      if (w_pop) begin
        r_out_valid     <= 1'b1;
        r_out_data      <= w_chunk;
        r_out_keep      <= w_keep;
        r_out_addr      <= r_chunk_idx;
        r_out_row_last  <= w_row_last;
        r_out_frame_end <= w_frame_end;
        if (w_row_last) begin
          r_row_rem   <= r_row_len;
          r_chunk_idx <= '0;
          r_row_idx   <= r_row_idx + LEN_W'(1);
        end else begin
          r_row_rem   <= r_row_rem - w_take_len;
          r_chunk_idx <= r_chunk_idx + LEN_W'(1);
        end
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      // The tail of the last input word beyond the frame is thrown away once
      // the final chunk has been handed off.
      if (r_state == S_DRAIN && r_out_valid && out_ready) begin
        r_buf   <= '0;
        r_level <= '0;
      end
    end
  end

  assign in_ready      = w_in_ready;
  assign out_valid     = r_out_valid;
  assign out_data      = r_out_data;
  assign out_keep      = r_out_keep;
  assign out_addr      = r_out_addr;
  assign out_row_last  = r_out_row_last;
  assign out_frame_end = r_out_frame_end;
  assign busy          = (r_state != S_IDLE);
  assign level         = r_level;

endmodule

// File: tb/tb_ifmap_repack_fifo.sv
// Testbench for ifmap_repack_fifo: scoreboard of expected chunks built from the
// frame geometry, compared at every output handshake.
module tb_ifmap_repack_fifo;

  localparam int IN_W   = 64;
  localparam int ELEM_W = 8;
  localparam int LANES  = 8;
  localparam int BUF_W  = 256;
  localparam int LEN_W  = 8;
  localparam int OUT_W  = LANES * ELEM_W;
  localparam int LVL_W  = $clog2(BUF_W + 1);

  logic               clk = 1'b0;
  logic               rst;
  logic               clear;
  logic               start;
  logic [LEN_W-1:0]   row_len;
  logic [LEN_W-1:0]   rows_per_frame;
  logic               in_valid;
  logic               in_ready;
  logic [IN_W-1:0]    in_data;
  logic               out_valid;
  logic               out_ready;
  logic [OUT_W-1:0]   out_data;
  logic [LANES-1:0]   out_keep;
  logic [LEN_W-1:0]   out_addr;
  logic               out_row_last;
  logic               out_frame_end;
  logic               busy;
  logic [LVL_W-1:0]   level;

  always #5 clk = ~clk;

  ifmap_repack_fifo #(
    .IN_W(IN_W), .ELEM_W(ELEM_W), .LANES(LANES), .BUF_W(BUF_W), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .start(start),
    .row_len(row_len), .rows_per_frame(rows_per_frame),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_keep(out_keep), .out_addr(out_addr), .out_row_last(out_row_last),
    .out_frame_end(out_frame_end), .busy(busy), .level(level)
  );

  typedef struct {
    logic [OUT_W-1:0] data;
    logic [LANES-1:0] keep;
    logic [LEN_W-1:0] addr;
    logic             row_last;
    logic             frame_end;
  } chunk_t;

  chunk_t exp_q[$];
  int     n_tests = 0;
  int     n_fail  = 0;
  int     cyc_cnt = 0;
  bit     drv_stop = 1'b0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Expected chunks of a frame whose byte stream is 0,1,2,...
  task automatic sb_frame(input int len, input int rows);
    int l, r, p, rem, take, addr;
    chunk_t c;
    l = (len == 0) ? 1 : len;
    r = (rows == 0) ? 1 : rows;
    p = 0;
    for (int row = 0; row < r; row++) begin
      rem  = l;
      addr = 0;
      while (rem > 0) begin
        take   = (rem < LANES) ? rem : LANES;
        c.data = '0;
        c.keep = '0;
        for (int k = 0; k < take; k++) begin
          c.data[8*k +: 8] = 8'(p + k);
          c.keep[k]        = 1'b1;
        end
        c.addr      = LEN_W'(addr);
        c.row_last  = (rem == take);
        c.frame_end = (rem == take) && (row == r - 1);
        exp_q.push_back(c);
        p    += take;
        rem  -= take;
        addr += 1;
      end
    end
  endtask

  task automatic start_frame(input int len, input int rows);
    row_len        = LEN_W'(len);
    rows_per_frame = LEN_W'(rows);
    start          = 1'b1;
    @(posedge clk); #1;
    start          = 1'b0;
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_busy: busy=%b required 1", busy);
    end
  endtask

  // Pushes nwords words carrying bytes 0..8*nwords-1.
  task automatic drive_words(input int nwords);
    int   w, cyc;
    logic rdy;
    w   = 0;
    cyc = 0;
    while (w < nwords && cyc < 500 && !drv_stop) begin
      in_valid = 1'b1;
      for (int b = 0; b < 8; b++) in_data[8*b +: 8] = 8'(8*w + b);
      rdy = in_ready;
      @(posedge clk); #1;
      cyc++;
      if (rdy) w++;
    end
    in_valid = 1'b0;
    n_tests++;
    if (w != nwords && !drv_stop) begin
      n_fail++;
      $display("FAIL drive_words: accepted=%0d required %0d", w, nwords);
    end
  endtask

  // Consumes nchunks chunks, stalling out_ready for stall_len cycles while
  // chunk index stall_at is presented.
  task automatic recv_chunks(input int nchunks, input int stall_at, input int stall_len,
                             output int first_cyc, output int last_cyc,
                             output int max_level, output bit saw_high);
    int     got, cyc, stall;
    logic   ov, rdy;
    chunk_t a, e, h;
    got = 0; cyc = 0; stall = 0;
    first_cyc = 0; last_cyc = 0; max_level = 0; saw_high = 1'b0;
    h = '{default: '0};
    while (got < nchunks && cyc < 1000) begin
      ov          = out_valid;
      a.data      = out_data;
      a.keep      = out_keep;
      a.addr      = out_addr;
      a.row_last  = out_row_last;
      a.frame_end = out_frame_end;
      if (ov && got == stall_at && stall < stall_len) begin
        if (stall == 0) begin
          h = a;
        end else begin
          n_tests++;
          if (a.data !== h.data || a.keep !== h.keep || a.addr !== h.addr) begin
            n_fail++;
            $display("FAIL hold: data=%h keep=%h addr=%0d required data=%h keep=%h addr=%0d",
                     a.data, a.keep, a.addr, h.data, h.keep, h.addr);
          end
        end
        out_ready = 1'b0;
        stall++;
      end else begin
        out_ready = 1'b1;
      end
      if (int'(level) > max_level) max_level = int'(level);
      if (int'(level) > BUF_W - IN_W) begin
        saw_high = 1'b1;
        n_tests++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL in_ready_high_level: in_ready=%b level=%0d required 0", in_ready, level);
        end
      end
      rdy = out_ready;
      @(posedge clk); #1;
      cyc++;
      if (ov && rdy) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL chunk_extra: data=%h keep=%h but none expected", a.data, a.keep);
        end else begin
          e = exp_q.pop_front();
          $display("[TB] chunk %0d data=%h keep=%h addr=%0d row_last=%b frame_end=%b",
                   got, a.data, a.keep, a.addr, a.row_last, a.frame_end);
          if (a.data !== e.data || a.keep !== e.keep || a.addr !== e.addr ||
              a.row_last !== e.row_last || a.frame_end !== e.frame_end) begin
            n_fail++;
            $display("FAIL chunk%0d: got data=%h keep=%h addr=%0d rl=%b fe=%b required data=%h keep=%h addr=%0d rl=%b fe=%b",
                     got, a.data, a.keep, a.addr, a.row_last, a.frame_end,
                     e.data, e.keep, e.addr, e.row_last, e.frame_end);
          end
        end
        got++;
        if (got == 1) first_cyc = cyc_cnt;
        last_cyc = cyc_cnt;
      end
    end
    out_ready = 1'b1;
    n_tests++;
    if (got != nchunks) begin
      n_fail++;
      $display("FAIL recv_timeout: chunks=%0d required %0d", got, nchunks);
    end
  endtask

  task automatic check_idle(input string name);
    n_tests++;
    if (busy !== 1'b0 || level !== '0 || in_ready !== 1'b0 || out_valid !== 1'b0 ||
        exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_idle: busy=%b level=%0d in_ready=%b out_valid=%b pending=%0d required 0 0 0 0 0",
               name, busy, level, in_ready, out_valid, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; start = 1'b0; row_len = '0; rows_per_frame = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_keep !== '0 || out_addr !== '0 ||
        out_row_last !== 1'b0 || out_frame_end !== 1'b0 || busy !== 1'b0 ||
        level !== '0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: ov=%b data=%h keep=%h busy=%b level=%0d in_ready=%b required all 0",
               out_valid, out_data, out_keep, busy, level, in_ready);
    end
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input string name, input int len, input int rows,
                           input int nwords, input int nchunks, input int stall_at,
                           input int stall_len, output int first_cyc, output int last_cyc,
                           output int max_level, output bit saw_high);
    int fc, lc, ml;
    bit sh;
    sb_frame(len, rows);
    start_frame(len, rows);
    fork
      drive_words(nwords);
      recv_chunks(nchunks, stall_at, stall_len, fc, lc, ml, sh);
    join
    first_cyc = fc; last_cyc = lc; max_level = ml; saw_high = sh;
    check_idle(name);
  endtask

  task automatic test_basic();
    int fc, lc, ml;
    bit sh;
    run_frame("basic", 22, 2, 6, 6, -1, 0, fc, lc, ml, sh);
  endtask

  task automatic test_backpressure();
    int fc, lc, ml;
    bit sh;
    run_frame("backpressure", 22, 2, 6, 6, 2, 10, fc, lc, ml, sh);
    n_tests++;
    if (sh !== 1'b1 || ml > BUF_W) begin
      n_fail++;
      $display("FAIL backpressure_level: saw_high=%b max_level=%0d required 1 and <=%0d",
               sh, ml, BUF_W);
    end
  endtask

  task automatic test_back_to_back();
    int fc, lc, ml;
    bit sh;
    run_frame("back_to_back", 16, 4, 8, 8, -1, 0, fc, lc, ml, sh);
    n_tests++;
    if (lc - fc != 7) begin
      n_fail++;
      $display("FAIL throughput: cycles first->last=%0d required 7", lc - fc);
    end
    n_tests++;
    if (ml != 64) begin
      n_fail++;
      $display("FAIL steady_level: max_level=%0d required 64", ml);
    end
  endtask

  task automatic test_short_rows();
    int fc, lc, ml;
    bit sh;
    run_frame("short_rows", 3, 3, 2, 3, -1, 0, fc, lc, ml, sh);
  endtask

  task automatic test_clear();
    int fc, lc, ml;
    bit sh;
    sb_frame(22, 2);
    start_frame(22, 2);
    drv_stop = 1'b0;
    fork
      drive_words(6);
      begin
        recv_chunks(3, -1, 0, fc, lc, ml, sh);
        clear    = 1'b1;
        drv_stop = 1'b1;
        @(posedge clk); #1;
        clear    = 1'b0;
      end
    join
    n_tests++;
    if (out_valid !== 1'b0 || level !== '0 || busy !== 1'b0 || in_ready !== 1'b0 ||
        out_keep !== '0 || out_data !== '0) begin
      n_fail++;
      $display("FAIL clear_state: ov=%b level=%0d busy=%b in_ready=%b keep=%h data=%h required all 0",
               out_valid, level, busy, in_ready, out_keep, out_data);
    end
    exp_q.delete();
    drv_stop = 1'b0;
    run_frame("after_clear", 22, 2, 6, 6, -1, 0, fc, lc, ml, sh);
  endtask

  task automatic test_async_reset();
    int fc, lc, ml;
    bit sh;
    start_frame(22, 2);
    out_ready = 1'b0;
    drive_words(2);
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_keep !== '0 || out_addr !== '0 ||
        out_row_last !== 1'b0 || out_frame_end !== 1'b0 || busy !== 1'b0 ||
        level !== '0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: ov=%b data=%h keep=%h busy=%b level=%0d in_ready=%b required all 0",
               out_valid, out_data, out_keep, busy, level, in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    run_frame("zero_len", 0, 2, 1, 2, -1, 0, fc, lc, ml, sh);
    run_frame("zero_rows", 5, 0, 1, 1, -1, 0, fc, lc, ml, sh);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_short_rows();
    test_clear();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
